mux_stream_nto1: RTL and testbench

Parametrised N-to-1 stream multiplexer with valid/ready handshakes, a registered output stage and two channel-selection modes: externally selected (fixed) or round-robin arbitration. It is the pipelined successor to the combinational 8-to-1 operand multiplexer and sits between the operand sources and the ALU input. It arbitrates among requesting channels and holds the selected word and its channel index until the consumer accepts it.

---
 rtl/mux_stream_nto1_if.sv | 29 ++
 rtl/mux_stream_nto1.sv | 195 +++++++++++++++++++
 tb/tb_mux_stream_nto1.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mux_stream_nto1_if.sv
// Stream bundle for mux_stream_nto1: N packed input channels with per-channel
// valid/ready, channel-selection controls, and one registered output stream
// carrying the data word and the index of the channel that produced it.
// The slave modport is the multiplexer's view; master is the environment's view.
interface mux_stream_nto1_if #(
  parameter int IN_WIDTH  = 32,
  parameter int NUM_CH    = 8,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
);
  logic [NUM_CH*IN_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH-1:0]          in_ready;
  logic                       mode;
  logic [SEL_WIDTH-1:0]       sel;
  logic [IN_WIDTH-1:0]        out_data;
  logic [SEL_WIDTH-1:0]       out_sel;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-to-1 valid/ready stream multiplexer with a single-entry
// registered output stage. Channel selection is either fixed (bus.sel) or
// round-robin (bus.mode = 1).
// Build option: define MUX_RR_EN to compile in the round-robin arbiter and its
// priority pointer. Without it, bus.mode is ignored and only fixed selection
// exists; out_sel then reports the sel value of the loaded word.

// Protocol checker kept beside the design; it only observes.
module mux_stream_nto1_chk #(
  parameter int IN_WIDTH  = 32,
  parameter int NUM_CH    = 8,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [NUM_CH-1:0]    in_ready,
  input logic [IN_WIDTH-1:0]  out_data,
  input logic [SEL_WIDTH-1:0] out_sel,
  input logic                 out_valid,
  input logic                 out_ready
);
  localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH+1)'(NUM_CH);

  // At most one channel may be offered the slot in any cycle.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready))
    else $error("in_ready has more than one bit set");

  // A stalled word must not be touched and no channel may be offered the slot.
  a_hold_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |-> (in_ready == '0))
    else $error("in_ready raised while output is stalled");

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)))
    else $error("output word changed while stalled");

  // The reported channel index always names an existing channel.
  a_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ({1'b0, out_sel} < NUM_CH_W))
    else $error("out_sel outside channel range");
endmodule

module mux_stream_nto1 #(
  parameter int IN_WIDTH  = 32,
  parameter int NUM_CH    = 8,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input logic            clk,
  input logic            rst_n,
  mux_stream_nto1_if.slave bus
);
  // Channel table is padded to the full index range so any SEL_WIDTH index is
  // a legal lookup; padding slots never carry valid data.
  localparam int                 CH_SLOTS = 2**SEL_WIDTH;
  localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH+1)'(NUM_CH);

  logic [IN_WIDTH-1:0]  ch_data_s [CH_SLOTS];
  logic [CH_SLOTS-1:0]  ch_valid_s;

  logic                 can_load_s;
  logic                 fix_gnt_vld_s;
  logic [SEL_WIDTH-1:0] fix_gnt_idx_s;
  logic                 gnt_vld_s;
  logic [SEL_WIDTH-1:0] gnt_idx_s;
  logic                 rr_mode_s;
  logic                 load_s;
  logic [NUM_CH-1:0]    in_ready_s;

  logic [IN_WIDTH-1:0]  out_data_r;
  logic [SEL_WIDTH-1:0] out_sel_r;
  logic                 out_valid_r;

  // Unpack the flat channel bus into an indexable table.
  for (genvar i = 0; i < CH_SLOTS; i++) begin : g_ch
    if (i < NUM_CH) begin : g_real
      assign ch_data_s[i]  = bus.in_data[i*IN_WIDTH +: IN_WIDTH];
      assign ch_valid_s[i] = bus.in_valid[i];
    end else begin : g_pad
      assign ch_data_s[i]  = '0;
      assign ch_valid_s[i] = 1'b0;
    end
  end

  // The output slot can accept a word when empty or when draining this cycle.
  assign can_load_s = !out_valid_r || bus.out_ready;

  // Fixed selection grants only indices that name a real channel.
  assign fix_gnt_vld_s = ({1'b0, bus.sel} < NUM_CH_W);
  assign fix_gnt_idx_s = bus.sel;

`ifdef MUX_RR_EN
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(NUM_CH - 1);

  logic [SEL_WIDTH-1:0] last_r;
  logic                 rr_gnt_vld_s;
  logic [SEL_WIDTH-1:0] rr_gnt_idx_s;

  assign rr_mode_s = bus.mode;

  // Round-robin search from last+1 upward with wrap; last itself is checked last.
  always_comb begin
    int  cand;
    logic hit;
    rr_gnt_vld_s = 1'b0;
    rr_gnt_idx_s = '0;
    cand         = 0;
    hit          = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(last_r) + k;
      cand = (cand >= NUM_CH) ? (cand - NUM_CH) : cand;
      hit  = !rr_gnt_vld_s && ch_valid_s[cand];
      rr_gnt_idx_s = hit ? SEL_WIDTH'(cand) : rr_gnt_idx_s;
      rr_gnt_vld_s = rr_gnt_vld_s | hit;
    end
  end

  // Pick the grant source according to the requested mode.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    if (rr_mode_s) begin
      gnt_vld_s = rr_gnt_vld_s;
      gnt_idx_s = rr_gnt_idx_s;
    end else begin
      gnt_vld_s = fix_gnt_vld_s;
      gnt_idx_s = fix_gnt_idx_s;
    end
  end

  // Priority pointer follows each round-robin transfer; fixed transfers leave it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= LAST_CH;
    end else if (load_s && rr_mode_s) begin
      last_r <= gnt_idx_s;
    end
  end
`else
  logic unused_mode_s;

  assign unused_mode_s = bus.mode;
  assign rr_mode_s     = 1'b0;

  // Only fixed selection exists in this build.
  always_comb begin
    gnt_vld_s = fix_gnt_vld_s;
    gnt_idx_s = fix_gnt_idx_s;
  end
`endif

  // Offer the slot to the granted channel only; independent of its valid.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready_s[i] = gnt_vld_s && can_load_s && (gnt_idx_s == SEL_WIDTH'(i));
    end
  end

  assign load_s = gnt_vld_s && can_load_s && ch_valid_s[gnt_idx_s];

  // Output register: load on input transfer, otherwise empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_sel_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= ch_data_s[gnt_idx_s];
      out_sel_r   <= gnt_idx_s;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;

  mux_stream_nto1_chk #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_CH    (NUM_CH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ready  (in_ready_s),
    .out_data  (out_data_r),
    .out_sel   (out_sel_r),
    .out_valid (out_valid_r),
    .out_ready (bus.out_ready)
  );
endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed bench for mux_stream_nto1: an 8-channel and a 6-channel instance,
// data word of channel i is 1000*i. Round-robin checks apply when MUX_RR_EN
// is defined; otherwise mode must be ignored.
module tb_mux_stream_nto1;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_stream_nto1_if #(.IN_WIDTH(32), .NUM_CH(8), .SEL_WIDTH(3)) bus8 ();
  mux_stream_nto1_if #(.IN_WIDTH(32), .NUM_CH(6), .SEL_WIDTH(3)) bus6 ();

  mux_stream_nto1 #(.IN_WIDTH(32), .NUM_CH(8), .SEL_WIDTH(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  mux_stream_nto1 #(.IN_WIDTH(32), .NUM_CH(6), .SEL_WIDTH(3)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out8(input string tag, input int ch, input logic vld);
    check_eq({tag, ".data"},  64'(bus8.out_data),  64'(1000*ch));
    check_eq({tag, ".sel"},   64'(bus8.out_sel),   64'(ch));
    check_eq({tag, ".valid"}, 64'(bus8.out_valid), 64'(vld));
  endtask

  initial begin
    int exp_rr [4];
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 8; i++) bus8.in_data[i*32 +: 32] = 32'(1000*i);
    for (int i = 0; i < 6; i++) bus6.in_data[i*32 +: 32] = 32'(1000*i);
    bus8.in_valid  = 8'hFF;
    bus8.mode      = 1'b0;
    bus8.sel       = 3'd0;
    bus8.out_ready = 1'b1;
    bus6.in_valid  = 6'h3F;
    bus6.mode      = 1'b0;
    bus6.sel       = 3'd7;
    bus6.out_ready = 1'b1;

    // Reset state
    tick();
    check_eq("rst.valid", 64'(bus8.out_valid), 64'd0);
    check_eq("rst.data",  64'(bus8.out_data),  64'd0);
    check_eq("rst.sel",   64'(bus8.out_sel),   64'd0);
    rst_n = 1'b1;

    // Fixed mode, sel stepping 0..7 each cycle
    for (int s = 0; s < 8; s++) begin
      bus8.sel = 3'(s);
      tick();
      check_out8($sformatf("fix%0d", s), s, 1'b1);
    end

    // Out-of-range select on the 6-channel instance
    check_eq("sel7.ready", 64'(bus6.in_ready),  64'd0);
    check_eq("sel7.valid", 64'(bus6.out_valid), 64'd0);
    bus6.sel = 3'd6;
    #1;
    check_eq("sel6.ready", 64'(bus6.in_ready), 64'd0);
    tick();
    check_eq("sel6.valid", 64'(bus6.out_valid), 64'd0);
    bus6.sel = 3'd5;
    #1;
    check_eq("sel5.ready", 64'(bus6.in_ready), 64'h20);
    tick();
    check_eq("sel5.data",  64'(bus6.out_data),  64'd5000);
    check_eq("sel5.sel",   64'(bus6.out_sel),   64'd5);
    check_eq("sel5.valid", 64'(bus6.out_valid), 64'd1);

    // Backpressure: register holds 7000/7 for 4 cycles
    bus8.out_ready = 1'b0;
    bus8.sel       = 3'd4;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("bp%0d.ready", c), 64'(bus8.in_ready), 64'd0);
      tick();
      check_out8($sformatf("bp%0d", c), 7, 1'b1);
    end
    bus8.out_ready = 1'b1;
    #1;
    check_eq("bprel.ready", 64'(bus8.in_ready), 64'h10);
    tick();
    check_out8("bprel", 4, 1'b1);

    // Drain with no input: valid clears, word held
    bus8.in_valid = 8'h00;
    tick();
    check_out8("drain", 4, 1'b0);

    // Mode switch while register holds channel 3
    bus8.out_ready = 1'b0;
`ifdef MUX_RR_EN
    bus8.mode     = 1'b1;
    bus8.in_valid = 8'h08;
`else
    bus8.sel      = 3'd3;
    bus8.in_valid = 8'hFF;
`endif
    tick();
    check_out8("msw.load", 3, 1'b1);
    bus8.mode     = 1'b0;
    bus8.sel      = 3'd6;
    bus8.in_valid = 8'hFF;
    tick();
    check_out8("msw.hold0", 3, 1'b1);
    tick();
    check_out8("msw.hold1", 3, 1'b1);
    bus8.out_ready = 1'b1;
    tick();
    check_out8("msw.next", 6, 1'b1);

`ifdef MUX_RR_EN
    // Pointer still at 3 after the fixed-mode transfer
    bus8.mode = 1'b1;
    tick();
    check_out8("rr.keep", 4, 1'b1);

    // Round-robin from reset: 0..7,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rr.ready0", 64'(bus8.in_ready), 64'h01);
    for (int k = 0; k < 9; k++) begin
      tick();
      check_out8($sformatf("rr%0d", k), k % 8, 1'b1);
    end
    exp_rr[0] = 2; exp_rr[1] = 5; exp_rr[2] = 2; exp_rr[3] = 5;
    bus8.in_valid = 8'h24;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out8($sformatf("rr25_%0d", k), exp_rr[k], 1'b1);
    end
    // Only the last-granted channel requesting: it wins again
    bus8.in_valid = 8'h20;
    tick();
    check_out8("rr.self", 5, 1'b1);
    bus8.in_valid = 8'h09;
`else
    // Mode is ignored in this build
    bus8.mode = 1'b1;
    bus8.sel  = 3'd2;
    tick();
    check_out8("noRR2", 2, 1'b1);
    bus8.sel = 3'd5;
    tick();
    check_out8("noRR5", 5, 1'b1);
    bus8.in_valid = 8'h09;
`endif

    // Asynchronous reset mid-stream
    bus8.sel = 3'd3;
    rst_n    = 1'b0;
    #1;
    check_eq("arst.valid",  64'(bus8.out_valid), 64'd0);
    check_eq("arst.data",   64'(bus8.out_data),  64'd0);
    check_eq("arst.sel",    64'(bus8.out_sel),   64'd0);
    check_eq("arst6.valid", 64'(bus6.out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
`ifdef MUX_RR_EN
    check_out8("arst.first", 0, 1'b1);
`else
    check_out8("arst.first", 3, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
